// File: rtl/ccg_bist_pkg.sv
// ---------------------------------------------------------------------------
// ccg_bist_pkg
// Shared definitions for the CCG BIST controller slice: the controller state
// encoding, stimulus/response widths, and the LFSR and MISR feedback taps.
// The one-step update functions are used by the controller for its pattern
// generator and by ccg_misr for signature compaction. The controller also
// uses the MISR step to look one update ahead.
// ---------------------------------------------------------------------------
package ccg_bist_pkg;

    localparam int PAT_W = 29;
    localparam int RSP_W = 28;

    // x^29 + x^27 + 1: feedback is cur[28] ^ cur[26]
    localparam logic [PAT_W-1:0] LFSR_TAPS = 29'h1400_0000;

    // x^28 + x^25 + 1: feedback is cur[27] ^ cur[24]
    localparam logic [RSP_W-1:0] MISR_TAPS = 28'h900_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } bist_state_e;

    // Shift left by one and insert the XOR of the tapped bits at bit 0
    function automatic logic [PAT_W-1:0] lfsrNext(input logic [PAT_W-1:0] cur);
        return {cur[PAT_W-2:0], ^(cur & LFSR_TAPS)};
    endfunction

    // Same shift/feedback structure, with the response folded in on every bit
    function automatic logic [RSP_W-1:0] misrNext(input logic [RSP_W-1:0] cur,
                                                  input logic [RSP_W-1:0] d);
        return {cur[RSP_W-2:0], ^(cur & MISR_TAPS)} ^ d;
    endfunction

endpackage

// File: rtl/ccg_misr.sv
// ---------------------------------------------------------------------------
// ccg_misr
// 28-bit multiple-input signature register that compacts circuit responses.
// Ports:
//   clk  in   rising-edge clock
//   rst  in   synchronous active-high reset, clears the signature
//   clr  in   synchronous clear at the start of a run
//   en   in   fold d into the signature this cycle
//   d    in   response vector
//   q    out  current signature
// ---------------------------------------------------------------------------
module ccg_misr
    import ccg_bist_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [RSP_W-1:0] d,
    output logic [RSP_W-1:0] q
);

    // Clear has priority over update so a run always starts from a zero
    // signature, even if a stale enable were present on the start cycle.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= '0;
        end else if (en) begin
            q <= misrNext(q, d);
        end
    end

endmodule

// File: rtl/ccg_bist_ctrl.sv
// ---------------------------------------------------------------------------
// ccg_bist_ctrl
// BIST controller: applies N_PAT LFSR patterns to the circuit under test,
// compacts the responses (arriving RSP_LAT cycles later) into a MISR, and
// reports the final signature and a pass flag against a golden value.
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   start      in   one-cycle run request (accepted only in IDLE)
//   seed       in   LFSR seed, zero is replaced by 1
//   golden     in   expected signature
//   pat_out    out  stimulus vector
//   rsp_in     in   response vector
//   busy       out  run in progress
//   done       out  one-cycle end-of-run pulse
//   pass       out  signature matched golden
//   signature  out  final MISR value
// ---------------------------------------------------------------------------
module ccg_bist_ctrl
    import ccg_bist_pkg::*;
#(
    parameter int N_PAT   = 1024,
    parameter int RSP_LAT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] seed,
    input  logic [RSP_W-1:0] golden,
    output logic [PAT_W-1:0] pat_out,
    input  logic [RSP_W-1:0] rsp_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [RSP_W-1:0] signature
);

    localparam logic [15:0] LAST_PAT   = 16'(N_PAT - 1);
    localparam logic [2:0]  LAST_DRAIN = 3'(RSP_LAT - 1);

    bist_state_e      state_q;
    logic [PAT_W-1:0] lfsr_q;
    logic [RSP_W-1:0] golden_q;
    logic [15:0]      patCnt_q;
    logic [2:0]       drainCnt_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic [RSP_W-1:0] sig_q;

    logic             capEn;
    logic             misrClr;
    logic [RSP_W-1:0] misr_q;
    logic [RSP_W-1:0] misr_d;
    logic [PAT_W-1:0] seedEff;

    assign misrClr = (state_q == IDLE) && start;
    assign seedEff = (seed == '0) ? PAT_W'(1) : seed;

    // Value the MISR will hold after this cycle; lets the final signature and
    // pass flag be registered on the same edge that raises done.
    assign misr_d = capEn ? misrNext(misr_q, rsp_in) : misr_q;

    // Capture qualification: a RUN cycle's response is valid RSP_LAT cycles
    // later, so the RUN flag is pushed down a shift register of that length.
    if (RSP_LAT == 0) begin : gNoDelay
        assign capEn = (state_q == RUN);
    end else begin : gDelay
        logic [RSP_LAT-1:0] vld_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q <= '0;
            end else begin
                vld_q <= (vld_q << 1) | RSP_LAT'(state_q == RUN);
            end
        end

        assign capEn = vld_q[RSP_LAT-1];
    end

    ccg_misr uMisr (
        .clk (clk),
        .rst (rst),
        .clr (misrClr),
        .en  (capEn),
        .d   (rsp_in),
        .q   (misr_q)
    );

    // Main controller FSM. lfsr_q is the presented pattern itself: it is loaded
    // with the seed on start, advances on every RUN cycle except the last, and
    // then holds through DRAIN, DONE and IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            lfsr_q     <= '0;
            golden_q   <= '0;
            patCnt_q   <= '0;
            drainCnt_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            sig_q      <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q  <= RUN;
                        lfsr_q   <= seedEff;
                        golden_q <= golden;
                        patCnt_q <= '0;
                        busy_q   <= 1'b1;
                    end
                end
                RUN: begin
                    patCnt_q <= patCnt_q + 16'd1;
                    if (patCnt_q == LAST_PAT) begin
                        drainCnt_q <= '0;
                        if (RSP_LAT == 0) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            sig_q   <= misr_d;
                            pass_q  <= (misr_d == golden_q);
                        end else begin
                            state_q <= DRAIN;
                        end
                    end else begin
                        lfsr_q <= lfsrNext(lfsr_q);
                    end
                end
                DRAIN: begin
                    if (drainCnt_q == LAST_DRAIN) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        sig_q   <= misr_d;
                        pass_q  <= (misr_d == golden_q);
                    end else begin
                        drainCnt_q <= drainCnt_q + 3'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign pat_out   = lfsr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign signature = sig_q;

endmodule

// File: tb/tb_ccg_bist_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ccg_bist_ctrl
// Five controller instances share clock, reset, seed, golden and response
// inputs, each with its own start bit. Instance g has N_PAT = g+1 for g<4 and
// N_PAT=8, RSP_LAT=3 for g=4, so within a run their done pulses fall on
// distinct cycles in index order. Expected results are pushed into a queue
// before each run and popped by an independent monitor on every done pulse.
// ---------------------------------------------------------------------------
module tb_ccg_bist_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  startV;
    logic [28:0] seed;
    logic [27:0] golden;
    logic [27:0] rspIn;

    logic [28:0] patOut [5];
    logic [27:0] sigV   [5];
    logic        busyV  [5];
    logic        doneV  [5];
    logic        passV  [5];

    typedef struct {
        int          dut;
        logic [27:0] sig;
        logic        pass;
        logic [28:0] last;
    } exp_t;

    exp_t        expQ [$];
    logic [28:0] patQ [$];
    exp_t        monE;
    int          testsRun    = 0;
    int          testsFailed = 0;
    int          busyCnt     = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 5; g++) begin : gDut
        ccg_bist_ctrl #(
            .N_PAT   ((g == 4) ? 8 : g + 1),
            .RSP_LAT ((g == 4) ? 3 : 0)
        ) uDut (
            .clk       (clk),
            .rst       (rst),
            .start     (startV[g]),
            .seed      (seed),
            .golden    (golden),
            .pat_out   (patOut[g]),
            .rsp_in    (rspIn),
            .busy      (busyV[g]),
            .done      (doneV[g]),
            .pass      (passV[g]),
            .signature (sigV[g])
        );
    end

    // One comparison: counts it and reports a FAIL line on mismatch
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic reportFail(input string name, input logic [31:0] act);
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL %s: observed %h, nothing expected", name, act);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit anyActive();
        for (int g = 0; g < 5; g++) begin
            if (busyV[g] || doneV[g]) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Pulse start on the masked instances; returns one cycle after acceptance
    task automatic applyStimulus(input logic [4:0] mask, input logic [28:0] sd,
                                 input logic [27:0] gd, input logic [27:0] rsp);
        seed   = sd;
        golden = gd;
        rspIn  = rsp;
        startV = mask;
        tick();
        startV = '0;
    endtask

    task automatic pushOne(input int g, input logic [27:0] sig, input logic [27:0] gd,
                           input logic [28:0] last);
        exp_t e;
        e.dut  = g;
        e.sig  = sig;
        e.pass = (sig == gd);
        e.last = last;
        expQ.push_back(e);
    endtask

    // Expectations for a run of all five instances. lasts holds each
    // instance's final pattern; for g=0..2 these are also the three patterns
    // instance 2 presents, in order.
    task automatic expectRun(input logic [27:0] gd, input logic [5*28-1:0] sigs,
                             input logic [5*29-1:0] lasts);
        for (int g = 0; g < 5; g++) pushOne(g, sigs[g*28 +: 28], gd, lasts[g*29 +: 29]);
        for (int g = 0; g < 3; g++) patQ.push_back(lasts[g*29 +: 29]);
    endtask

    task automatic waitIdle();
        int n = 0;
        while (anyActive() && n < 60) begin
            tick();
            n++;
        end
        if (n >= 60) reportFail("run completion timeout", 32'(n));
        tick();
    endtask

    // Monitor: checks instance 2's patterns while busy, counts instance 4's
    // busy cycles, and compares every done pulse against the queue head.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                busyCnt = 0;
            end else begin
                if (busyV[4]) busyCnt++;
                if (busyV[2]) begin
                    if (patQ.size() == 0) reportFail("unexpected pattern", patOut[2]);
                    else checkOutput("pattern dut2", 32'(patOut[2]), 32'(patQ.pop_front()));
                end
                for (int g = 0; g < 5; g++) begin
                    if (doneV[g]) begin
                        if (expQ.size() == 0) begin
                            reportFail($sformatf("unexpected done dut%0d", g), 32'(sigV[g]));
                        end else begin
                            monE = expQ.pop_front();
                            checkOutput("done order", 32'(g), 32'(monE.dut));
                            checkOutput($sformatf("signature dut%0d", g), 32'(sigV[g]), 32'(monE.sig));
                            checkOutput($sformatf("pass dut%0d", g), 32'(passV[g]), 32'(monE.pass));
                            checkOutput($sformatf("last pattern dut%0d", g), 32'(patOut[g]), 32'(monE.last));
                            if (g == 4) checkOutput("busy cycles dut4", 32'(busyCnt), 32'd11);
                        end
                        if (g == 4) busyCnt = 0;
                    end
                end
            end
        end
    end

    // Stop a hung simulation
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed run sequence with hand-computed signatures and patterns
    initial begin
        rst    = 1'b1;
        startV = '0;
        seed   = '0;
        golden = '0;
        rspIn  = '0;
        repeat (3) tick();
        rst = 1'b0;

        for (int g = 0; g < 5; g++) begin
            checkOutput($sformatf("reset pat_out dut%0d", g), 32'(patOut[g]), 32'd0);
            checkOutput($sformatf("reset busy dut%0d", g), 32'(busyV[g]), 32'd0);
            checkOutput($sformatf("reset done dut%0d", g), 32'(doneV[g]), 32'd0);
            checkOutput($sformatf("reset pass dut%0d", g), 32'(passV[g]), 32'd0);
            checkOutput($sformatf("reset signature dut%0d", g), 32'(sigV[g]), 32'd0);
        end

        // Seed 1, zero responses, golden 0: signature 0 and pass everywhere
        expectRun(28'h0, {5{28'h0}},
                  {29'h80, 29'h8, 29'h4, 29'h2, 29'h1});
        applyStimulus(5'h1F, 29'h1, 28'h0, 28'h0);
        waitIdle();

        // Zero seed, all-ones responses, golden 1; a second start with a
        // different seed arrives while instances are in RUN or DONE
        expectRun(28'h1, {28'h0000055, 28'h0000005, 28'hFFFFFFD, 28'h0000001, 28'hFFFFFFF},
                  {29'h80, 29'h8, 29'h4, 29'h2, 29'h1});
        applyStimulus(5'h1F, 29'h0, 28'h1, 28'hFFFFFFF);
        tick();
        seed   = 29'h1234;
        startV = 5'h1F;
        tick();
        startV = '0;
        waitIdle();

        // Start on the IDLE cycle right after DONE is accepted (instance 0)
        pushOne(0, 28'hFFFFFFF, 28'hFFFFFFF, 29'h10000000);
        pushOne(0, 28'hFFFFFFF, 28'hFFFFFFF, 29'h10000000);
        applyStimulus(5'b00001, 29'h10000000, 28'hFFFFFFF, 28'hFFFFFFF);
        tick();
        tick();
        startV = 5'b00001;
        tick();
        startV = '0;
        waitIdle();

        // Seed with bit 28 set exercises the x^29 tap; golden 1 must fail
        expectRun(28'h1, {5{28'h0}},
                  {29'h40, 29'h4, 29'h2, 29'h1, 29'h10000000});
        applyStimulus(5'h1F, 29'h10000000, 28'h1, 28'h0);
        waitIdle();

        // Seed with bit 26 set, response on bit 27 exercises both feedback taps
        expectRun(28'h8000003, {28'h800007F, 28'h8000007, 28'h8000003, 28'h8000001, 28'h8000000},
                  {29'h50, 29'h5, 29'h10000002, 29'h8000001, 29'h4000000});
        applyStimulus(5'h1F, 29'h04000000, 28'h8000003, 28'h8000000);
        waitIdle();

        // Reset during the fifth RUN cycle of instance 4: no done, outputs clear
        applyStimulus(5'b10000, 29'h1, 28'h0, 28'hFFFFFFF);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int g = 0; g < 5; g++) begin
            checkOutput($sformatf("abort pat_out dut%0d", g), 32'(patOut[g]), 32'd0);
            checkOutput($sformatf("abort busy dut%0d", g), 32'(busyV[g]), 32'd0);
            checkOutput($sformatf("abort done dut%0d", g), 32'(doneV[g]), 32'd0);
            checkOutput($sformatf("abort pass dut%0d", g), 32'(passV[g]), 32'd0);
            checkOutput($sformatf("abort signature dut%0d", g), 32'(sigV[g]), 32'd0);
        end
        repeat (15) tick();

        // Clean run after the abort, response on bit 24 exercises the MISR tap
        expectRun(28'hF000070, {28'hF000070, 28'hF000007, 28'h7000003, 28'h3000001, 28'h1000000},
                  {29'h80, 29'h8, 29'h4, 29'h2, 29'h1});
        applyStimulus(5'h1F, 29'h1, 28'hF000070, 28'h1000000);
        waitIdle();
        repeat (3) tick();

        checkOutput("expected results left over", 32'(expQ.size()), 32'd0);
        checkOutput("expected patterns left over", 32'(patQ.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/ccg_bist_ctrl.md
CCG_BIST_CTRL -- requirements
Module: ccg_bist_ctrl

Interface
REQ-001 SHALL have parameter N_PAT, default 1024, meaning the number of patterns applied per run (legal range 1..65535).
REQ-002 SHALL have parameter RSP_LAT, default 0, meaning the response latency in cycles from pat_out to a valid rsp_in (legal range 0..7).
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 SHALL have these ports, one per line (name, direction, width, meaning):
  clk        in   1   rising-edge clock
  rst        in   1   synchronous active-high reset
  start      in   1   one-cycle run request
  seed       in   29  LFSR seed, sampled on an accepted start
  golden     in   28  expected signature, sampled on an accepted start
  pat_out    out  29  stimulus vector, bit i drives circuit input x<i>
  rsp_in     in   28  response vector, bit i is circuit output f<i+1>
  busy       out  1   run in progress
  done       out  1   one-cycle pulse at end of run
  pass       out  1   signature equals golden, valid from done until the next accepted start
  signature  out  28  final MISR value, held until the next accepted start

Function
REQ-005 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-006 SHALL transition IDLE->RUN on start=1; on that cycle it latches seed (a zero seed SHALL be replaced by 29'h1) and golden, clears the MISR to 0, clears pat_cnt, and sets busy=1 on the next cycle.
REQ-007 In RUN, pat_out SHALL present the current LFSR value, and the LFSR SHALL advance each cycle as next = {cur[27:0], cur[28]^cur[26]} (x^29+x^27+1).
REQ-008 The first pattern applied SHALL be the latched seed itself; exactly N_PAT distinct consecutive patterns are applied.
REQ-009 pat_cnt SHALL be 16 bits wide and increment per applied pattern; RUN->DRAIN when the N_PAT-th pattern is applied.
REQ-010 A capture-valid delay line of length RSP_LAT SHALL qualify rsp_in; the MISR SHALL update only on qualified cycles, exactly N_PAT times per run.
REQ-011 MISR update (x^28+x^25+1): next[0] = cur[27]^cur[24]^rsp_in[0]; next[i] = cur[i-1]^rsp_in[i] for i = 1..27.
REQ-012 DRAIN SHALL last RSP_LAT cycles (zero cycles when RSP_LAT=0, i.e. RUN->DONE directly) and SHALL hold pat_out at the last pattern.
REQ-013 DONE SHALL last one cycle: done=1, busy=0, signature <= MISR, pass <= (MISR == golden latched); then DONE->IDLE.
REQ-014 start SHALL be ignored while busy=1 or in DONE; start in IDLE on the cycle after DONE SHALL be accepted.
REQ-015 In IDLE, pat_out SHALL hold its last value, and the LFSR and MISR SHALL not change.
REQ-016 All outputs SHALL be registered; there SHALL be no combinational path from any input to any output.

Reset
REQ-017 rst=1 SHALL force IDLE, pat_out=0, busy=0, done=0, pass=0, signature=0, MISR=0, pat_cnt=0, and the delay line to 0.
REQ-018 rst asserted mid-run SHALL abort the run with no done pulse; reset SHALL take priority over start in the same cycle.

Structure
REQ-019 A shared package ccg_bist_pkg SHALL hold the state enum, PAT_W=29, RSP_W=28, and the LFSR and MISR tap constants.
REQ-020 The MISR SHALL be a separate sub-module ccg_misr (clk, rst, clr, en, d[27:0], q[27:0]); the LFSR and FSM SHALL be inline.

Verification
REQ-021 seed=29'h1, N_PAT=3, RSP_LAT=0 -> pat_out sequence 29'h1, 29'h2, 29'h4; done asserted 1 cycle after the third pattern.
REQ-022 rsp_in tied 28'hFFFFFFF, N_PAT=1 -> signature=28'hFFFFFFF; N_PAT=2 -> signature=28'h0000001; pass=1 iff golden matches.
REQ-023 rsp_in tied 0, golden=0, N_PAT=4 -> signature=0, pass=1; golden=1 -> pass=0.
REQ-024 seed=0 -> first pattern 29'h1; start pulsed while busy -> no restart, and pat_cnt is unaffected.
REQ-025 RSP_LAT=3, N_PAT=8 -> exactly 8 MISR updates, busy high for 11 cycles, and signature matches the reference model.
REQ-026 rst asserted in the 5th RUN cycle -> all outputs 0 on the next cycle and no done; a new start then runs cleanly from seed.
